// File: rtl/axil_uart_pkg.sv
// Register map, status/control bit positions and response codes for the AXI-Lite UART slave.
package axil_uart_pkg;

  localparam logic [3:0] OFF_RX   = 4'h0;
  localparam logic [3:0] OFF_TX   = 4'h4;
  localparam logic [3:0] OFF_STAT = 4'h8;
  localparam logic [3:0] OFF_CTRL = 4'hC;

  // Only addr[3:2] selects a register.
  localparam logic [1:0] SEL_RX   = OFF_RX[3:2];
  localparam logic [1:0] SEL_TX   = OFF_TX[3:2];
  localparam logic [1:0] SEL_STAT = OFF_STAT[3:2];
  localparam logic [1:0] SEL_CTRL = OFF_CTRL[3:2];

  localparam int STAT_RX_NEMPTY = 0;
  localparam int STAT_RX_FULL   = 1;
  localparam int STAT_TX_EMPTY  = 2;
  localparam int STAT_TX_FULL   = 3;
  localparam int STAT_IE        = 4;
  localparam int STAT_OVERRUN   = 5;

  localparam int CTRL_FLUSH_TX = 0;
  localparam int CTRL_FLUSH_RX = 1;
  localparam int CTRL_IE       = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_AW,
    WR_W,
    WR_EXEC,
    WR_RESP
  } wr_state_t;

endpackage

// File: rtl/axil_uart_slave_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; flush beats push/pop, push at full is allowed only with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             pop,
  output logic [WIDTH-1:0] o_data,
  input  logic             flush,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/axil_uart_slave.sv
// AXI-Lite register front end for a byte-stream UART with TX/RX FIFOs.
// Defining UARTLITE_INTR_EN adds the o_interrupt port and its pulse logic.
module axil_uart_slave
  import axil_uart_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [7:0]                o_tx_data,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_valid,
  output logic                      o_rx_ready
`ifdef UARTLITE_INTR_EN
  ,
  output logic                      o_interrupt
`endif
);

  // Every channel is a valid/ready pair: a beat transfers on the rising edge where both are 1.
  wr_state_t                 r_wr_state;
  wr_state_t                 w_wr_next;
  logic                      r_out_en;
  logic [1:0]                r_aw_sel;
  logic [7:0]                r_wdata;
  logic                      r_rvalid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic                      r_ie;
  logic                      r_overrun;

  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_ar_hs;
  logic                      w_exec;
  logic [1:0]                w_ar_sel;
  logic [7:0]                w_stat;
  logic [AXI_DATA_WIDTH-1:0] w_rd_data;
  logic                      w_overrun_set;
  logic                      w_unused;

  logic       w_tx_push, w_tx_pop, w_tx_flush, w_tx_full, w_tx_empty;
  logic       w_rx_push, w_rx_pop, w_rx_flush, w_rx_full, w_rx_empty;
  logic [7:0] w_rx_head;

  assign w_aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_w_hs   = s_axi_wvalid && s_axi_wready;
  assign w_ar_hs  = s_axi_arvalid && s_axi_arready;
  assign w_exec   = (r_wr_state == WR_EXEC);
  assign w_ar_sel = s_axi_araddr[3:2];
  assign w_unused = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:4], s_axi_awaddr[1:0],
                      s_axi_araddr[AXI_ADDR_WIDTH-1:4], s_axi_araddr[1:0],
                      s_axi_wdata[AXI_DATA_WIDTH-1:8]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_wr_state <= WR_IDLE;
    else       r_wr_state <= w_wr_next;
  end

  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE: begin
        if (w_aw_hs && w_w_hs) w_wr_next = WR_EXEC;
        else if (w_aw_hs)      w_wr_next = WR_AW;
        else if (w_w_hs)       w_wr_next = WR_W;
      end
      WR_AW:   if (w_w_hs)  w_wr_next = WR_EXEC;
      WR_W:    if (w_aw_hs) w_wr_next = WR_EXEC;
      WR_EXEC: w_wr_next = WR_RESP;
      WR_RESP: if (s_axi_bready) w_wr_next = WR_IDLE;
      default: w_wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = RESP_OKAY;
    case (r_wr_state)
      WR_IDLE: begin
        s_axi_awready = r_out_en;
        s_axi_wready  = r_out_en;
      end
      WR_AW:   s_axi_wready  = r_out_en;
      WR_W:    s_axi_awready = r_out_en;
      WR_RESP: s_axi_bvalid  = 1'b1;
      default: ;
    endcase
  end

  assign s_axi_arready = r_out_en && !r_rvalid;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = RESP_OKAY;

  assign w_tx_push  = w_exec && (r_aw_sel == SEL_TX);
  assign w_tx_flush = w_exec && (r_aw_sel == SEL_CTRL) && r_wdata[CTRL_FLUSH_TX];
  assign w_tx_pop   = o_tx_valid && i_tx_ready;
  assign o_tx_valid = !w_tx_empty;

  assign w_rx_flush    = w_exec && (r_aw_sel == SEL_CTRL) && r_wdata[CTRL_FLUSH_RX];
  assign w_rx_pop      = w_ar_hs && (w_ar_sel == SEL_RX) && !w_rx_empty;
  assign o_rx_ready    = r_out_en && (!w_rx_full || w_rx_pop);
  assign w_rx_push     = i_rx_valid && o_rx_ready;
  assign w_overrun_set = i_rx_valid && w_rx_full && !w_rx_pop;

  always_comb begin
    w_stat                 = '0;
    w_stat[STAT_RX_NEMPTY] = !w_rx_empty;
    w_stat[STAT_RX_FULL]   = w_rx_full;
    w_stat[STAT_TX_EMPTY]  = w_tx_empty;
    w_stat[STAT_TX_FULL]   = w_tx_full;
    w_stat[STAT_IE]        = r_ie;
    w_stat[STAT_OVERRUN]   = r_overrun;
    w_rd_data              = '0;
    case (w_ar_sel)
      SEL_RX:   if (!w_rx_empty) w_rd_data[7:0] = w_rx_head;
      SEL_STAT: w_rd_data[7:0] = w_stat;
      default:  ;
    endcase
  end

  // r_out_en keeps all readies low until the first edge after reset release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_en  <= 1'b0;
      r_aw_sel  <= '0;
      r_wdata   <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_ie      <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_out_en <= 1'b1;
      if (w_aw_hs) r_aw_sel <= s_axi_awaddr[3:2];
      if (w_w_hs)  r_wdata  <= s_axi_wdata[7:0];
      if (w_exec && (r_aw_sel == SEL_CTRL)) r_ie <= r_wdata[CTRL_IE];
      if (w_overrun_set) r_overrun <= 1'b1;
      else if (w_ar_hs && (w_ar_sel == SEL_STAT)) r_overrun <= 1'b0;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .push   (w_tx_push),
    .i_data (r_wdata),
    .pop    (w_tx_pop),
    .o_data (o_tx_data),
    .flush  (w_tx_flush),
    .full   (w_tx_full),
    .empty  (w_tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .push   (w_rx_push),
    .i_data (i_rx_data),
    .pop    (w_rx_pop),
    .o_data (w_rx_head),
    .flush  (w_rx_flush),
    .full   (w_rx_full),
    .empty  (w_rx_empty)
  );

`ifdef UARTLITE_INTR_EN
  logic r_rx_empty_d;
  logic r_tx_empty_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_empty_d <= 1'b1;
      r_tx_empty_d <= 1'b1;
    end else begin
      r_rx_empty_d <= w_rx_empty;
      r_tx_empty_d <= w_tx_empty;
    end
  end

  // Edge detect against last cycle's empty flags yields a single-cycle pulse.
  assign o_interrupt = r_ie && ((r_rx_empty_d && !w_rx_empty) || (!r_tx_empty_d && w_tx_empty));
`endif

endmodule

// File: tb/tb_axil_uart_slave.sv
// Directed bench for axil_uart_slave: register access, FIFO boundaries, split handshakes, reset.
module tb_axil_uart_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_ready;
`ifdef UARTLITE_INTR_EN
  logic        o_interrupt;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  int          tx_pops = 0;
  int          tx_valid_cycles = 0;
  int          irq_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  axil_uart_slave dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .i_rx_data     (i_rx_data),
    .i_rx_valid    (i_rx_valid),
    .o_rx_ready    (o_rx_ready)
`ifdef UARTLITE_INTR_EN
    ,
    .o_interrupt   (o_interrupt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // TX scoreboard: every accepted TX byte must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst && o_tx_valid) begin
      tx_valid_cycles++;
      if (i_tx_ready) begin
        tx_pops++;
        if (exp_q.size() > 0) chk("tx_data", {24'b0, o_tx_data}, exp_q.pop_front());
        else                  chk("tx_extra", {24'b0, o_tx_data}, 32'h100);
      end
    end
`ifdef UARTLITE_INTR_EN
    if (o_interrupt) irq_cnt++;
`endif
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done = 0;
    int n = 0;
    s_axi_awaddr = addr; s_axi_wdata = data;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge clk);
      if (s_axi_awvalid && s_axi_awready) aw_done = 1;
      if (s_axi_wvalid && s_axi_wready)   w_done = 1;
      @(posedge clk); #1;
      if (aw_done) s_axi_awvalid = 1'b0;
      if (w_done)  s_axi_wvalid = 1'b0;
      n++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("wr_timeout", n, 0);
    resp = s_axi_bresp;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs = 0;
    int n = 0;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = s_axi_arready;
      @(posedge clk); #1;
      n++;
    end
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("rd_timeout", n, 0);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, output logic accepted);
    i_rx_data = b; i_rx_valid = 1'b1;
    @(negedge clk);
    accepted = o_rx_ready;
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp, rresp;
    logic [31:0] rdata;
    logic        acc;
    int          base, cnt;

    #12;
    chk("rst_outputs", {o_tx_valid, s_axi_bvalid, s_axi_rvalid, s_axi_awready,
                        s_axi_wready, s_axi_arready, o_rx_ready}, 0);
`ifdef UARTLITE_INTR_EN
    chk("rst_irq", o_interrupt, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("readies_after_rst", {s_axi_awready, s_axi_wready, s_axi_arready, o_rx_ready}, 4'hF);

    // Single TX byte straight through to the stream
    i_tx_ready = 1'b1;
    exp_q.push_back(32'h41);
    axi_write(32'h4, 32'h41, resp);
    chk("tx_bresp", resp, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    chk("tx_valid_one_cycle", tx_valid_cycles, 1);

    axi_read(32'h4, rdata, rresp);
    chk("read_wo_tx", rdata, 0);
    chk("read_wo_rresp", rresp, 2'b00);
    axi_write(32'h8, 32'hFF, resp);
    chk("write_ro_bresp", resp, 2'b00);
    axi_read(32'h8, rdata, rresp);
    chk("stat_idle", rdata, 32'h04);

    // AW accepted at t, W at t+3: one B beat at t+4
    s_axi_bready = 1'b0; s_axi_awaddr = 32'hC; s_axi_wdata = 32'h0;
    s_axi_awvalid = 1'b1;
    @(negedge clk); chk("split_awready", s_axi_awready, 1);
    @(posedge clk); #1; s_axi_awvalid = 1'b0;
    @(negedge clk); chk("split_awready_drop", s_axi_awready, 0);
    @(posedge clk); @(posedge clk); #1; s_axi_wvalid = 1'b1;
    @(negedge clk); chk("split_wready", s_axi_wready, 1);
    @(posedge clk); #1; s_axi_wvalid = 1'b0;
    @(negedge clk); chk("split_b_early", s_axi_bvalid, 0);
    @(negedge clk); chk("split_bvalid", s_axi_bvalid, 1);
    chk("split_bresp", s_axi_bresp, 2'b00);
    chk("split_no_aw_in_b", {s_axi_awready, s_axi_wready}, 0);
    @(negedge clk); chk("split_b_hold", s_axi_bvalid, 1);
    s_axi_bready = 1'b1;
    @(posedge clk); #1; s_axi_bready = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (s_axi_bvalid) cnt++;
    end
    chk("split_single_b", cnt, 0);
    @(posedge clk); #1;

    // Concurrent read and write complete independently
    exp_q.push_back(32'h55);
    fork
      axi_write(32'h4, 32'h55, resp);
      axi_read(32'h8, rdata, rresp);
    join
    chk("conc_bresp", resp, 2'b00);
    chk("conc_rresp", rresp, 2'b00);
    chk("conc_stat", rdata, 32'h04);
    repeat (3) @(posedge clk);
    #1;
    chk("conc_tx_pops", tx_pops, 2);

    // RX overrun: 17 bytes into a 16-entry FIFO, TX holding one byte
    i_tx_ready = 1'b0;
    axi_write(32'h4, 32'h5A, resp);
    for (int b = 0; b < 17; b++) begin
      rx_send(8'(b), acc);
      chk("rx_accept", acc, (b < 16) ? 1 : 0);
    end
    axi_read(32'h8, rdata, rresp);
    chk("stat_overrun", rdata, 32'h23);
    axi_read(32'h8, rdata, rresp);
    chk("stat_overrun_clr", rdata, 32'h03);
    for (int i = 0; i < 11; i++) begin
      axi_read(32'h0, rdata, rresp);
      chk("rx_data", rdata, i);
    end
    for (int i = 0; i < 4; i++) axi_write(32'h4, 32'h5B + i, resp);
    axi_read(32'h8, rdata, rresp);
    chk("stat_five_each", rdata, 32'h01);
    axi_write(32'hC, 32'h3, resp);
    axi_read(32'h8, rdata, rresp);
    chk("stat_after_flush", rdata, 32'h04);
    axi_read(32'h0, rdata, rresp);
    chk("rx_empty_read", rdata, 0);

    // TX full: 17th write is dropped, 16 bytes drain in order
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(32'h80 + i);
      axi_write(32'h4, 32'h80 + i, resp);
    end
    axi_read(32'h8, rdata, rresp);
    chk("stat_tx_full", rdata, 32'h08);
    i_tx_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("tx_drain_pops", tx_pops, 18);
    chk("tx_drain_q", exp_q.size(), 0);

    // Interrupt enable bit and RX-arrival pulse
    axi_write(32'hC, 32'h10, resp);
    axi_read(32'h8, rdata, rresp);
    chk("stat_ie", rdata, 32'h14);
    base = irq_cnt;
    rx_send(8'h77, acc);
    chk("irq_rx_accept", acc, 1);
    repeat (4) @(posedge clk);
    #1;
`ifdef UARTLITE_INTR_EN
    chk("irq_pulse", irq_cnt - base, 1);
`endif
    axi_read(32'h0, rdata, rresp);
    chk("irq_rx_data", rdata, 32'h77);
    axi_write(32'hC, 32'h0, resp);

    // Reset while a read response is stalled
    s_axi_rready = 1'b0; s_axi_araddr = 32'h8; s_axi_arvalid = 1'b1;
    @(posedge clk); #1; s_axi_arvalid = 1'b0;
    @(negedge clk); chk("rst_pre_rvalid", s_axi_rvalid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {s_axi_rvalid, s_axi_bvalid, o_tx_valid, s_axi_awready,
                            s_axi_wready, s_axi_arready, o_rx_ready}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    s_axi_rready = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_axi_rvalid) cnt++;
    end
    chk("no_r_after_rst", cnt, 0);
    chk("readies_after_rst2", {s_axi_awready, s_axi_wready, s_axi_arready, o_rx_ready}, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
